pc060ha_master_seq: RTL

- Master-side initiator for the nibble-wide PC060HA mailbox protocol.
- Turns byte-level commands (send byte, receive byte, assert/release slave reset) into sequences of 4-bit index/data bus accesses against the chip's master port.
- Polls the status register so the main CPU never has to bit-bang the handshake.
- Sits between a main-CPU register front-end and the chip's nMCS/nMRD/nMWR/MA0/MD pins.

---
 rtl/pc060ha_master_seq.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/pc060ha_master_seq.sv
// rtl/pc060ha_master_seq.sv - PC060HA master-port command sequencer
// Turns byte send/receive/slave-reset commands into nibble index/data accesses.
module pc060ha_master_seq #(
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 2,
  parameter int POLL_LIMIT    = 255
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic       CMD_CH,
  input  logic [7:0] CMD_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       RSP_TIMEOUT,
  output logic       nMCS,
  output logic       nMRD,
  output logic       nMWR,
  output logic       MA0,
  output logic [3:0] MD_OUT,
  output logic       MD_OE,
  input  logic [3:0] MD_IN
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_GAP, S_RESP} state_t;
  typedef enum logic [2:0] {P_IDX4, P_POLL, P_IDX, P_LO, P_HI, P_RST} phase_t;

  localparam logic [1:0] OP_SEND   = 2'b00;
  localparam logic [1:0] OP_RST_ON = 2'b10;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] poll_q, poll_d, poll_inc;
  logic [1:0]  op_q, op_d;
  logic        ch_q, ch_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  rd_q, rd_d;
  logic [3:0]  lo_q, lo_d;
  logic [7:0]  rsp_q, rsp_d;
  logic        timeout_q, timeout_d;

  logic        acc_wr, acc_a0, poll_ok, poll_hit;
  logic [3:0]  acc_d;

  assign RSP_DATA = rsp_q;

  // Bus access implied by the current sequencer phase
  always_comb begin
    acc_wr = 1'b1;
    acc_a0 = 1'b0;
    acc_d  = 4'h0;
    case (phase_q)
      P_IDX4: acc_d = 4'd4;
      P_POLL: begin
        acc_wr = 1'b0;
        acc_a0 = 1'b1;
      end
      P_IDX:  acc_d = {2'b00, ch_q, 1'b0};
      P_LO: begin
        acc_a0 = 1'b1;
        acc_wr = (op_q == OP_SEND);
        acc_d  = data_q[3:0];
      end
      P_HI: begin
        acc_a0 = 1'b1;
        acc_wr = (op_q == OP_SEND);
        acc_d  = data_q[7:4];
      end
      P_RST: begin
        acc_a0 = 1'b1;
        acc_d  = {3'b000, (op_q == OP_RST_ON)};
      end
      default: acc_d = 4'h0;
    endcase
  end

  // Send waits for outbound-pending to clear; receive waits for inbound-available
  assign poll_ok  = (op_q == OP_SEND) ? !rd_q[{1'b0, ch_q}] : rd_q[{1'b1, ch_q}];
  assign poll_inc = poll_q + 16'd1;
  assign poll_hit = (POLL_LIMIT != 0) && (poll_inc == 16'(POLL_LIMIT));

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    poll_d      = poll_q;
    op_d        = op_q;
    ch_d        = ch_q;
    data_d      = data_q;
    rd_d        = rd_q;
    lo_d        = lo_q;
    rsp_d       = rsp_q;
    timeout_d   = timeout_q;
    CMD_READY   = 1'b0;
    RSP_VALID   = 1'b0;
    RSP_TIMEOUT = 1'b0;
    nMCS        = 1'b1;
    nMRD        = 1'b1;
    nMWR        = 1'b1;
    MA0         = 1'b0;
    MD_OUT      = 4'h0;
    MD_OE       = 1'b0;

    case (state_q)
      S_IDLE, S_RESP: begin
        CMD_READY   = 1'b1;
        RSP_VALID   = (state_q == S_RESP);
        RSP_TIMEOUT = (state_q == S_RESP) && timeout_q;
        state_d     = S_IDLE;
        if (CMD_VALID) begin
          op_d      = CMD_OP;
          ch_d      = CMD_CH;
          data_d    = CMD_DATA;
          phase_d   = P_IDX4;
          poll_d    = 16'd0;
          timeout_d = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        // Address settles one cycle before nMCS falls
        MA0     = acc_a0;
        MD_OUT  = acc_wr ? acc_d : 4'h0;
        MD_OE   = acc_wr;
        cnt_d   = 8'd0;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        MA0    = acc_a0;
        MD_OUT = acc_wr ? acc_d : 4'h0;
        MD_OE  = acc_wr;
        nMCS   = 1'b0;
        nMRD   = acc_wr;
        nMWR   = !acc_wr;
        if (cnt_q == 8'(STROBE_CYCLES - 1)) begin
          if (!acc_wr) rd_d = MD_IN;
          cnt_d   = 8'd0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        // Write data stays on the pads past the strobe rising edge
        MA0    = acc_a0;
        MD_OUT = acc_wr ? acc_d : 4'h0;
        MD_OE  = acc_wr && (cnt_q == 8'd0);
        if (cnt_q == 8'(GAP_CYCLES - 1)) begin
          cnt_d   = 8'd0;
          state_d = S_SETUP;
          case (phase_q)
            P_IDX4: phase_d = op_q[1] ? P_RST : P_POLL;
            P_POLL: begin
              poll_d = poll_inc;
              if (poll_ok) begin
                phase_d = P_IDX;
              end else if (poll_hit) begin
                timeout_d = 1'b1;
                state_d   = S_RESP;
              end
            end
            P_IDX: phase_d = P_LO;
            P_LO: begin
              lo_d    = rd_q;
              phase_d = P_HI;
            end
            P_HI: begin
              if (!acc_wr) rsp_d = {rd_q, lo_q};
              state_d = S_RESP;
            end
            default: state_d = S_RESP;
          endcase
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      phase_q   <= P_IDX4;
      cnt_q     <= 8'd0;
      poll_q    <= 16'd0;
      op_q      <= 2'b00;
      ch_q      <= 1'b0;
      data_q    <= 8'h00;
      rd_q      <= 4'h0;
      lo_q      <= 4'h0;
      rsp_q     <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      poll_q    <= poll_d;
      op_q      <= op_d;
      ch_q      <= ch_d;
      data_q    <= data_d;
      rd_q      <= rd_d;
      lo_q      <= lo_d;
      rsp_q     <= rsp_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
